// File: rtl/block_seq_ctrl_pkg.sv
// Shared types for the decoder-block sequencer: stage/phase encodings and
// the select codes driven alongside the projection and layer-norm start pulses.
package block_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LN1,
    ST_PRJ_Q,
    ST_PRJ_K,
    ST_PRJ_V,
    ST_QK,
    ST_ATTN,
    ST_PRJ_O,
    ST_LN2,
    ST_FFN1,
    ST_FFN2,
    ST_DONE,
    ST_ERR
  } stage_e;

  typedef enum logic {
    PH_ISSUE,
    PH_WAIT
  } phase_e;

  localparam logic [1:0] PROJ_Q = 2'd0;
  localparam logic [1:0] PROJ_K = 2'd1;
  localparam logic [1:0] PROJ_V = 2'd2;
  localparam logic [1:0] PROJ_O = 2'd3;

  localparam logic LN_1 = 1'b0;
  localparam logic LN_2 = 1'b1;

endpackage

// File: rtl/block_seq_ctrl_wdog.sv
// Per-stage watchdog: cleared while a stage issues, counts while it waits and
// flags expiry on the wait cycle that brings the count to all-ones.
module stage_wdog #(
  parameter int WDOG_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [WDOG_W-1:0] CNT_MAX = '1;

  logic [WDOG_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry is signalled one wait cycle early so the FSM leaves exactly as the count saturates.
  assign expired_o = enable_i && (cnt_q >= (CNT_MAX - 1'b1));

endmodule

// File: rtl/block_seq_ctrl.sv
// Decoder-block sequencer: runs N_LAYERS layers of LN1, Q/K/V proj, per-head QK/ATTN,
// O proj, LN2, FFN1, FFN2, with abort, stray-done detection and a stage watchdog.
module block_seq_ctrl
  import block_ctrl_pkg::*;
#(
  parameter int N_LAYERS = 12,
  parameter int N_HEADS  = 4,
  parameter int WDOG_W   = 16,
  parameter int LAYER_W  = $clog2(N_LAYERS > 1 ? N_LAYERS : 2),
  parameter int HEAD_W   = $clog2(N_HEADS > 1 ? N_HEADS : 2)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run_i,
  input  logic               abort_i,
  output logic               busy_o,
  output logic               run_done_o,
  output logic               error_o,
  output logic               stray_done_o,
  output logic [LAYER_W-1:0] layer_idx_o,
  output logic [HEAD_W-1:0]  head_idx_o,
  output logic [1:0]         proj_sel_o,
  output logic               ln_sel_o,
  output logic               ln_start_o,
  output logic               proj_start_o,
  output logic               qk_matmul_start_o,
  output logic               attn_reader_start_o,
  output logic               linear1_start_o,
  output logic               linear2_start_o,
  input  logic               ln_done_i,
  input  logic               proj_done_i,
  input  logic               qk_matmul_done_i,
  input  logic               attn_reader_done_i,
  input  logic               linear1_done_i,
  input  logic               linear2_done_i
);

  stage_e stage_q, stage_d;
  phase_e phase_q, phase_d;
  logic [LAYER_W-1:0] layer_q, layer_d;
  logic [HEAD_W-1:0]  head_q, head_d;
  logic stray_q, stray_d;
  logic wdog_expired;
  logic done_match;
  logic [5:0] done_vec, accept_vec;

  assign done_vec = {linear2_done_i, linear1_done_i, attn_reader_done_i,
                     qk_matmul_done_i, proj_done_i, ln_done_i};

  stage_wdog #(.WDOG_W(WDOG_W)) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (phase_q == PH_ISSUE),
    .enable_i (phase_q == PH_WAIT),
    .expired_o(wdog_expired)
  );

  // Only the done belonging to the stage being waited on is accepted; anything else is stray.
  always_comb begin
    accept_vec = '0;
    if (phase_q == PH_WAIT) begin
      case (stage_q)
        ST_LN1, ST_LN2:                       accept_vec[0] = 1'b1;
        ST_PRJ_Q, ST_PRJ_K, ST_PRJ_V, ST_PRJ_O: accept_vec[1] = 1'b1;
        ST_QK:                                accept_vec[2] = 1'b1;
        ST_ATTN:                              accept_vec[3] = 1'b1;
        ST_FFN1:                              accept_vec[4] = 1'b1;
        ST_FFN2:                              accept_vec[5] = 1'b1;
        default:                              accept_vec    = '0;
      endcase
    end
    done_match = |(done_vec & accept_vec);
  end

  always_comb begin
    stage_d = stage_q;
    phase_d = phase_q;
    layer_d = layer_q;
    head_d  = head_q;
    stray_d = stray_q | (|(done_vec & ~accept_vec));
    if (abort_i) begin
      stage_d = ST_IDLE;
      phase_d = PH_ISSUE;
      layer_d = '0;
      head_d  = '0;
      stray_d = 1'b0;
    end else begin
      case (stage_q)
        ST_IDLE: begin
          if (run_i) begin
            stage_d = ST_LN1;
            phase_d = PH_ISSUE;
          end
        end
        ST_DONE: stage_d = ST_IDLE;
        ST_ERR:  stage_d = ST_ERR;
        default: begin
          if (phase_q == PH_ISSUE) begin
            phase_d = PH_WAIT;
          end else if (done_match) begin
            phase_d = PH_ISSUE;
            case (stage_q)
              ST_LN1:   stage_d = ST_PRJ_Q;
              ST_PRJ_Q: stage_d = ST_PRJ_K;
              ST_PRJ_K: stage_d = ST_PRJ_V;
              ST_PRJ_V: stage_d = ST_QK;
              ST_QK:    stage_d = ST_ATTN;
              ST_ATTN: begin
                if (head_q == HEAD_W'(N_HEADS - 1)) begin
                  stage_d = ST_PRJ_O;
                  head_d  = '0;
                end else begin
                  stage_d = ST_QK;
                  head_d  = head_q + 1'b1;
                end
              end
              ST_PRJ_O: stage_d = ST_LN2;
              ST_LN2:   stage_d = ST_FFN1;
              ST_FFN1:  stage_d = ST_FFN2;
              ST_FFN2: begin
                if (layer_q == LAYER_W'(N_LAYERS - 1)) begin
                  stage_d = ST_DONE;
                  layer_d = '0;
                end else begin
                  stage_d = ST_LN1;
                  layer_d = layer_q + 1'b1;
                end
              end
              default:  stage_d = ST_ERR;
            endcase
          end else if (wdog_expired) begin
            stage_d = ST_ERR;
            phase_d = PH_ISSUE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= ST_IDLE;
      phase_q <= PH_ISSUE;
      layer_q <= '0;
      head_q  <= '0;
      stray_q <= 1'b0;
    end else begin
      stage_q <= stage_d;
      phase_q <= phase_d;
      layer_q <= layer_d;
      head_q  <= head_d;
      stray_q <= stray_d;
    end
  end

  // Start pulses and selects decode straight from the state flops, so they never glitch on inputs.
  always_comb begin
    ln_start_o          = 1'b0;
    proj_start_o        = 1'b0;
    qk_matmul_start_o   = 1'b0;
    attn_reader_start_o = 1'b0;
    linear1_start_o     = 1'b0;
    linear2_start_o     = 1'b0;
    proj_sel_o          = PROJ_Q;
    ln_sel_o            = LN_1;
    case (stage_q)
      ST_LN1:   ln_start_o = (phase_q == PH_ISSUE);
      ST_LN2: begin
        ln_start_o = (phase_q == PH_ISSUE);
        ln_sel_o   = LN_2;
      end
      ST_PRJ_Q: proj_start_o = (phase_q == PH_ISSUE);
      ST_PRJ_K: begin
        proj_start_o = (phase_q == PH_ISSUE);
        proj_sel_o   = PROJ_K;
      end
      ST_PRJ_V: begin
        proj_start_o = (phase_q == PH_ISSUE);
        proj_sel_o   = PROJ_V;
      end
      ST_PRJ_O: begin
        proj_start_o = (phase_q == PH_ISSUE);
        proj_sel_o   = PROJ_O;
      end
      ST_QK:    qk_matmul_start_o   = (phase_q == PH_ISSUE);
      ST_ATTN:  attn_reader_start_o = (phase_q == PH_ISSUE);
      ST_FFN1:  linear1_start_o     = (phase_q == PH_ISSUE);
      ST_FFN2:  linear2_start_o     = (phase_q == PH_ISSUE);
      default:  ln_start_o          = 1'b0;
    endcase
  end

  assign busy_o       = (stage_q != ST_IDLE) && (stage_q != ST_DONE);
  assign run_done_o   = (stage_q == ST_DONE);
  assign error_o      = (stage_q == ST_ERR);
  assign stray_done_o = stray_q;
  assign layer_idx_o  = layer_q;
  assign head_idx_o   = head_q;

endmodule
